// File: rtl/adc_serial_avg.sv
// adc_serial_avg: serial ADC front end for CHANNELS data lines sharing one
// chip select and SCLK. It generates the sample-rate tick, captures a frame per
// tick, presents the raw samples and keeps a power-of-two block average per
// channel.
// Optional build macro ADC_HISTORY_EN adds hist_data, which holds the last
// three block averages of every channel.
module adc_serial_avg #(
    parameter int CLK_DIV    = 50,
    parameter int SAMPLE_DIV = 2268,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int WIDTH      = 12,
    parameter int CHANNELS   = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic                         clk100MHz,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [CHANNELS-1:0]          sdata,
    output logic                         adc_cs_n,
    output logic                         adc_sclk,
    output logic                         sample_tick,
    output logic                         sample_valid,
    output logic [CHANNELS*WIDTH-1:0]    sample_data,
    output logic                         avg_valid,
    output logic [CHANNELS*WIDTH-1:0]    avg_data,
    output logic                         overrun
`ifdef ADC_HISTORY_EN
    ,
    output logic [CHANNELS*3*WIDTH-1:0]  hist_data
`endif
);

    localparam int TICK_W  = $clog2(SAMPLE_DIV + 1);
    localparam int PHASE_W = $clog2(2 * CLK_DIV + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);
    localparam int ACC_W   = WIDTH + AVG_LOG2;
    localparam int CNT_W   = AVG_LOG2 + 1;

    localparam logic [TICK_W-1:0]  TICK_LAST    = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(2 * CLK_DIV - 1);
    localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(CLK_DIV - 1);
    localparam logic [PHASE_W-1:0] LOW_LEN      = PHASE_W'(CLK_DIV);
    localparam logic [BIT_W-1:0]   BIT_LAST     = BIT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'((1 << AVG_LOG2) - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [TICK_W-1:0]     tickCnt;
    logic [PHASE_W-1:0]    phaseCnt;
    logic [BIT_W-1:0]      bitCnt;
    logic [CNT_W-1:0]      sampleCnt;
    logic [FRAME_BITS-1:0] frameReg [CHANNELS];
    logic [ACC_W-1:0]      accReg   [CHANNELS];
    logic [ACC_W-1:0]      accSum   [CHANNELS];
    logic [WIDTH-1:0]      newSample[CHANNELS];
    logic [WIDTH-1:0]      newAvg   [CHANNELS];
    logic                  blockEnd;

    // Pins decode straight from the frame state: SCLK low for the first half of each bit.
    assign adc_cs_n    = (state != CONV);
    assign adc_sclk    = !((state == CONV) && (phaseCnt < LOW_LEN));
    assign sample_tick = enable && (tickCnt == TICK_LAST);

    // Sample-rate counter, parked at zero while disabled.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            tickCnt <= '0;
        end else if (!enable || tickCnt == TICK_LAST) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + TICK_W'(1);
        end
    end

    // Frame sequencer: one tick starts a frame that always runs to completion.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            phaseCnt <= '0;
            bitCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phaseCnt <= '0;
                    bitCnt   <= '0;
                    if (sample_tick) begin
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (phaseCnt == PHASE_LAST) begin
                        phaseCnt <= '0;
                        if (bitCnt == BIT_LAST) begin
                            state <= DONE;
                        end else begin
                            bitCnt <= bitCnt + BIT_W'(1);
                        end
                    end else begin
                        phaseCnt <= phaseCnt + PHASE_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flag for ticks that land on a busy sequencer.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (sample_tick && state != IDLE) begin
            overrun <= 1'b1;
        end
    end

    // Shift each data line in MSB first, one cycle before SCLK rises.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                frameReg[ch] <= '0;
            end
        end else if (state == CONV && phaseCnt == SAMPLE_PHASE) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                frameReg[ch] <= {frameReg[ch][FRAME_BITS-2:0], sdata[ch]};
            end
        end
    end

    // Data field extraction and the running block sum including the new sample.
    always_comb begin
        blockEnd = (sampleCnt == CNT_LAST);
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            newSample[ch] = frameReg[ch][DATA_BITS-1 -: WIDTH];
            accSum[ch]    = accReg[ch] + ACC_W'(newSample[ch]);
            newAvg[ch]    = WIDTH'(accSum[ch] >> AVG_LOG2);
        end
    end

    // Publish samples and block averages; a disabled idle sequencer restarts the block.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            sample_valid <= 1'b0;
            avg_valid    <= 1'b0;
            sample_data  <= '0;
            avg_data     <= '0;
            sampleCnt    <= '0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                accReg[ch] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            avg_valid    <= 1'b0;
            if (state == DONE) begin
                sample_valid <= 1'b1;
                for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                    sample_data[ch*WIDTH +: WIDTH] <= newSample[ch];
                end
                if (blockEnd) begin
                    avg_valid <= 1'b1;
                    sampleCnt <= '0;
                    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                        avg_data[ch*WIDTH +: WIDTH] <= newAvg[ch];
                        accReg[ch] <= '0;
                    end
                end else begin
                    sampleCnt <= sampleCnt + CNT_W'(1);
                    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                        accReg[ch] <= accSum[ch];
                    end
                end
            end else if (!enable && state == IDLE) begin
                sampleCnt <= '0;
                for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                    accReg[ch] <= '0;
                end
            end
        end
    end

`ifdef ADC_HISTORY_EN
    // Three-deep average history per channel, newest in the low slot.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            hist_data <= '0;
        end else if (state == DONE && blockEnd) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                hist_data[ch*3*WIDTH +: 3*WIDTH] <=
                    {hist_data[ch*3*WIDTH +: 2*WIDTH], newAvg[ch]};
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_serial_avg.sv
// Testbench for adc_serial_avg: randomized ADC frame model, scoreboard queues
// filled at frame start and drained by monitors on sample_valid/avg_valid.
// A second instance with a too-short SAMPLE_DIV exercises overrun.
// Build with ADC_HISTORY_EN defined to include the history checks.
module tb_adc_serial_avg;
    localparam int CD  = 2;
    localparam int SD  = 80;
    localparam int SD2 = 40;
    localparam int FB  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN, enable, enable2;
    logic [1:0]  sdata1, sdata2;
    logic        cs1, sclk1, tick1, sv1, av1, ov1;
    logic        cs2, sclk2, tick2, sv2, av2, ov2;
    logic [23:0] sd1, ad1, sd2, ad2;
`ifdef ADC_HISTORY_EN
    logic [71:0] hist1, hist2;
`endif

    adc_serial_avg #(.CLK_DIV(CD), .SAMPLE_DIV(SD), .FRAME_BITS(FB), .DATA_BITS(12),
                     .WIDTH(12), .CHANNELS(2), .AVG_LOG2(2)) dut (
        .clk100MHz(clk), .reset(resetN), .enable(enable), .sdata(sdata1),
        .adc_cs_n(cs1), .adc_sclk(sclk1), .sample_tick(tick1), .sample_valid(sv1),
        .sample_data(sd1), .avg_valid(av1), .avg_data(ad1), .overrun(ov1)
`ifdef ADC_HISTORY_EN
        , .hist_data(hist1)
`endif
    );

    adc_serial_avg #(.CLK_DIV(CD), .SAMPLE_DIV(SD2), .FRAME_BITS(FB), .DATA_BITS(12),
                     .WIDTH(12), .CHANNELS(2), .AVG_LOG2(2)) dutOvr (
        .clk100MHz(clk), .reset(resetN), .enable(enable2), .sdata(sdata2),
        .adc_cs_n(cs2), .adc_sclk(sclk2), .sample_tick(tick2), .sample_valid(sv2),
        .sample_data(sd2), .avg_valid(av2), .avg_data(ad2), .overrun(ov2)
`ifdef ADC_HISTORY_EN
        , .hist_data(hist2)
`endif
    );

    int cyc;
    always @(posedge clk) cyc++;

    int checks;
    int passes;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic failNote(input string name);
        checks++;
        $display("FAIL %s: event did not match expectation (cycle %0d)", name, cyc);
    endtask

    // ---------------- ADC model + reference for the main instance ----------------
    logic [15:0] dirQ0[$];
    logic [15:0] dirQ1[$];
    logic [15:0] word0, word1;
    logic [23:0] expQ1[$];
    logic [23:0] avgQ1[$];
    bit          avgDueQ[$];
    logic [23:0] lastExp1;
    int bitIdx1 = FB, rises1, lastRise1, sclkBad1, lastTick1, validCount1;
    int blkSum0, blkSum1, blkCnt;

    assign sdata1[0] = (bitIdx1 < FB) ? word0[FB-1-bitIdx1] : 1'b0;
    assign sdata1[1] = (bitIdx1 < FB) ? word1[FB-1-bitIdx1] : 1'b0;

    always @(negedge cs1) begin
        if (dirQ0.size() > 0) word0 = dirQ0.pop_front(); else word0 = 16'($urandom);
        if (dirQ1.size() > 0) word1 = dirQ1.pop_front(); else word1 = 16'($urandom);
        bitIdx1 = 0;
        rises1  = 0;
        expQ1.push_back({word1[11:0], word0[11:0]});
        blkSum0 += int'(word0[11:0]);
        blkSum1 += int'(word1[11:0]);
        blkCnt++;
        if (blkCnt == 4) begin
            avgQ1.push_back({12'(blkSum1 / 4), 12'(blkSum0 / 4)});
            avgDueQ.push_back(1'b1);
            blkSum0 = 0;
            blkSum1 = 0;
            blkCnt  = 0;
        end else begin
            avgDueQ.push_back(1'b0);
        end
    end

    always @(posedge sclk1) begin
        if (cs1 === 1'b0) begin
            bitIdx1++;
            rises1++;
            if (rises1 > 1 && cyc - lastRise1 != 2 * CD) sclkBad1++;
            lastRise1 = cyc;
        end
    end

    always @(negedge clk) begin
        logic [23:0] e;
        bit due;
        if (tick1) lastTick1 = cyc;
        if (sv1) begin
            validCount1++;
            if (expQ1.size() == 0) begin
                failNote("sample_valid_unexpected");
            end else begin
                e = expQ1.pop_front();
                due = avgDueQ.pop_front();
                lastExp1 = e;
                check("sample_data", 64'(sd1), 64'(e));
                check("tick_to_valid", 64'(cyc - lastTick1), 64'(66));
                check("sclk_rises", 64'(rises1), 64'(16));
                check("sclk_period", 64'(sclkBad1), 64'(0));
                check("avg_valid", 64'(av1), 64'(due));
                if (av1 && due) begin
                    e = avgQ1.pop_front();
                    check("avg_data", 64'(ad1), 64'(e));
`ifdef ADC_HISTORY_EN
                    check("hist_slot0", 64'({hist1[47:36], hist1[11:0]}), 64'(e));
`endif
                end
            end
        end else if (av1) begin
            failNote("avg_valid_without_sample");
        end
    end

    // ---------------- ADC model + reference for the overrun instance ----------------
    logic [15:0] word2a, word2b;
    logic [23:0] expQ2[$];
    int bitIdx2 = FB, rises2, lastRise2, sclkBad2, csFall2;

    assign sdata2[0] = (bitIdx2 < FB) ? word2a[FB-1-bitIdx2] : 1'b0;
    assign sdata2[1] = (bitIdx2 < FB) ? word2b[FB-1-bitIdx2] : 1'b0;

    always @(negedge cs2) begin
        word2a  = 16'($urandom);
        word2b  = 16'($urandom);
        bitIdx2 = 0;
        rises2  = 0;
        csFall2 = cyc;
        expQ2.push_back({word2b[11:0], word2a[11:0]});
    end

    always @(posedge sclk2) begin
        if (cs2 === 1'b0) begin
            bitIdx2++;
            rises2++;
            if (rises2 > 1 && cyc - lastRise2 != 2 * CD) sclkBad2++;
            lastRise2 = cyc;
        end
    end

    always @(negedge clk) begin
        logic [23:0] e;
        if (sv2) begin
            if (expQ2.size() == 0) begin
                failNote("ovr_valid_unexpected");
            end else begin
                e = expQ2.pop_front();
                check("ovr_sample_data", 64'(sd2), 64'(e));
                check("ovr_latency", 64'(cyc - csFall2), 64'(65));
                check("ovr_sclk_rises", 64'(rises2), 64'(16));
                check("ovr_sclk_period", 64'(sclkBad2), 64'(0));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic waitValids(input int n);
        int target;
        int budget;
        target = validCount1 + n;
        budget = n * SD + 300;
        while (validCount1 < target && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        if (validCount1 < target) failNote("wait_sample_valid_timeout");
    endtask

    task automatic waitCsLow();
        int budget;
        budget = 2 * SD + 50;
        while (cs1 !== 1'b0 && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        if (cs1 !== 1'b0) failNote("wait_cs_low_timeout");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int firstTick;
        int ticks;
        int vc;
        resetN  = 1'b0;
        enable  = 1'b1;
        enable2 = 1'b1;
        firstTick = -1;

        // Reset held with enable high: pins idle, outputs zero, no ticks.
        repeat (6) begin
            @(negedge clk);
            check("reset_state", 64'({cs1, sclk1, tick1, sv1, av1, ov1, sd1, ad1}),
                  64'({1'b1, 1'b1, 4'b0000, 48'd0}));
        end

        dirQ0.push_back(16'h0ABC);
        dirQ1.push_back(16'h0123);
        @(posedge clk); #2 resetN = 1'b1;

        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (tick1) begin
                firstTick = n;
                break;
            end
        end
        check("first_tick_delay", 64'(firstTick), 64'(79));
        check("overrun_before_extra_tick", 64'(ov2), 64'(0));
        @(posedge clk); #1;
        check("overrun_after_extra_tick", 64'(ov2), 64'(1));

        // Single directed frame.
        waitValids(1);
        check("single_frame", 64'(sd1), 64'(24'h123ABC));

        // Complete the first block, then directed averaging blocks.
        repeat (3) dirQ0.push_back(16'($urandom));
        dirQ0.push_back({4'($urandom), 12'd100});
        dirQ0.push_back({4'($urandom), 12'd101});
        dirQ0.push_back({4'($urandom), 12'd102});
        dirQ0.push_back({4'($urandom), 12'd104});
        repeat (4) dirQ0.push_back(16'hFFFF);
        waitValids(7);
        check("avg_101", 64'(ad1[11:0]), 64'(101));
        waitValids(4);
        check("avg_4095_no_wrap", 64'(ad1[11:0]), 64'(12'hFFF));

        // Random traffic.
        waitValids(9);

        // Drop enable 10 cycles into a frame.
        waitCsLow();
        repeat (10) @(posedge clk);
        #2 enable = 1'b0;
        waitValids(1);
        ticks = 0;
        repeat (200) begin
            @(negedge clk);
            if (tick1) ticks++;
        end
        check("no_ticks_disabled", 64'(ticks), 64'(0));
        check("cs_idle_disabled", 64'(cs1), 64'(1));
        check("sample_held", 64'(sd1), 64'(lastExp1));
        blkSum0 = 0;
        blkSum1 = 0;
        blkCnt  = 0;
        repeat (4) dirQ0.push_back(16'h0008);
        @(posedge clk); #2 enable = 1'b1;
        waitValids(4);
        check("avg_after_reenable", 64'(ad1[11:0]), 64'(8));

        check("overrun_sticky", 64'(ov2), 64'(1));
        check("overrun_main_clear", 64'(ov1), 64'(0));

        // Reset in the middle of a frame.
        waitCsLow();
        repeat (20) @(posedge clk);
        #2 resetN = 1'b0;
        expQ1.delete();
        avgQ1.delete();
        avgDueQ.delete();
        expQ2.delete();
        dirQ0.delete();
        dirQ1.delete();
        blkSum0 = 0;
        blkSum1 = 0;
        blkCnt  = 0;
        #1;
        check("reset_midframe_pins", 64'({cs1, sclk1, sv1, ov2}), 64'(4'b1100));
        vc = validCount1;
        repeat (5) @(posedge clk);
        #2 resetN = 1'b1;
        repeat (4) dirQ0.push_back(16'd5);
        repeat (4) dirQ0.push_back(16'd6);
        repeat (4) dirQ0.push_back(16'd7);
        repeat (4) dirQ0.push_back(16'd9);
        repeat (60) @(posedge clk);
        #2;
        check("no_valid_after_abort", 64'(validCount1), 64'(vc));
        check("overrun_cleared_by_reset", 64'(ov2), 64'(0));
        waitValids(16);
        check("avg_9", 64'(ad1[11:0]), 64'(9));
`ifdef ADC_HISTORY_EN
        check("history_ch0", 64'(hist1[35:0]), 64'({12'd6, 12'd7, 12'd9}));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
